// File: rtl/sd_mem_2p_flow.sv
// Two-port RAM: byte-enabled write port, srdy/drdy read request channel and an
// in-order return buffer sized so that p_drdy backpressure can never drop data.
module sd_mem_2p_flow #(
  parameter int width   = 32,
  parameter int depth   = 64,
  parameter int addr_sz = $clog2(depth),
  parameter int rd_lat  = 1,
  parameter int be_sz   = width / 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [addr_sz-1:0] wr_addr,
  input  logic [be_sz-1:0]   wr_be,
  input  logic [width-1:0]   d_in,
  input  logic               rd_srdy,
  output logic               rd_drdy,
  input  logic [addr_sz-1:0] rd_addr,
  output logic               p_srdy,
  input  logic               p_drdy,
  output logic [width-1:0]   p_data
);

  localparam int cap   = rd_lat + 1;
  localparam int ptr_w = $clog2(cap);
  localparam int cnt_w = $clog2(cap + 1);
  localparam logic [addr_sz:0] depth_lim = (addr_sz + 1)'(depth);

  logic [width-1:0] mem_q [depth];

  logic             wr_ok, rd_ok, acc, pop, push;
  logic [width-1:0] rd_word, push_data;

  logic [width-1:0] buf_q [cap];
  logic [width-1:0] buf_d [cap];
  logic [ptr_w-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w-1:0] fcnt_q, fcnt_d, cnt_q, cnt_d;
  logic             rd_drdy_q, rd_drdy_d, p_srdy_q, p_srdy_d;

  function automatic logic [ptr_w-1:0] nxt(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(cap - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  always_comb begin
    wr_ok = {1'b0, wr_addr} < depth_lim;
    rd_ok = {1'b0, rd_addr} < depth_lim;
    acc   = rd_srdy & rd_drdy_q;
    pop   = p_srdy_q & p_drdy;
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok)
      for (int unsigned i = 0; i < be_sz; i++)
        if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= d_in[8*i +: 8];
  end

  // Write-first: a read accepted alongside a write to the same word sees the merged bytes.
  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem_q[rd_addr];
      if (wr_en && wr_ok && (wr_addr == rd_addr))
        for (int unsigned i = 0; i < be_sz; i++)
          if (wr_be[i]) rd_word[8*i +: 8] = d_in[8*i +: 8];
    end
  end

  if (rd_lat == 1) begin : g_lat1
    always_comb begin
      push      = acc;
      push_data = rd_word;
    end
  end else begin : g_lat2
    logic             stg_vld_q, stg_vld_d;
    logic [width-1:0] stg_dat_q, stg_dat_d;

    always_comb begin
      stg_vld_d = acc;
      stg_dat_d = acc ? rd_word : stg_dat_q;
      push      = stg_vld_q;
      push_data = stg_dat_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stg_vld_q <= 1'b0;
        stg_dat_q <= '0;
      end else begin
        stg_vld_q <= stg_vld_d;
        stg_dat_q <= stg_dat_d;
      end
    end
  end

  // The outstanding count covers the pipeline stage as well as the buffer, so a
  // buffer of cap entries can always absorb whatever is in flight.
  always_comb begin
    buf_d  = buf_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      buf_d[wptr_q] = push_data;
      wptr_d        = nxt(wptr_q);
    end
    if (pop) rptr_d = nxt(rptr_q);
    fcnt_d    = fcnt_q + cnt_w'(push) - cnt_w'(pop);
    cnt_d     = cnt_q + cnt_w'(acc) - cnt_w'(pop);
    rd_drdy_d = cnt_d < cnt_w'(cap);
    p_srdy_d  = fcnt_d != '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q     <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      fcnt_q    <= '0;
      cnt_q     <= '0;
      rd_drdy_q <= 1'b1;
      p_srdy_q  <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fcnt_q    <= fcnt_d;
      cnt_q     <= cnt_d;
      rd_drdy_q <= rd_drdy_d;
      p_srdy_q  <= p_srdy_d;
    end
  end

  always_comb begin
    rd_drdy = rd_drdy_q;
    p_srdy  = p_srdy_q;
    p_data  = buf_q[rptr_q];
  end

endmodule
